// File: rtl/frame_buf_pkg.sv
// Shared frame-buffer constants and arbiter state encoding.
package frame_buf_pkg;

    localparam int unsigned FB_ADDR_W       = 15;
    localparam int unsigned FB_DATA_W       = 24;
    localparam int unsigned FB_DEPTH        = 16;
    localparam int unsigned FB_STARVE_LIMIT = 8;
    localparam logic [23:0] FB_CLEAR_COLOR  = 24'h000000;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_read_pipe.sv
// Two-stage valid shift register tracking display reads through the
// registered address stage and the one-cycle RAM read latency.
module fb_read_pipe (
    input  logic clk,
    input  logic rst,
    input  logic grant,
    output logic valid
);

    logic stage1;

    // Shift the grant two cycles; reset flushes any read in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage1 <= 1'b0;
            valid  <= 1'b0;
        end else begin
            stage1 <= grant;
            valid  <= stage1;
        end
    end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Single-port frame buffer arbiter: display reads, game-logic writes and a
// built-in clear engine share one RAM port with starvation protection.
module frame_buf_arbiter
    import frame_buf_pkg::*;
#(
    parameter int unsigned       ADDR_W       = FB_ADDR_W,
    parameter int unsigned       DATA_W       = FB_DATA_W,
    parameter int unsigned       DEPTH        = FB_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_COLOR  = DATA_W'(FB_CLEAR_COLOR),
    parameter int unsigned       STARVE_LIMIT = FB_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_miss,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int unsigned       SC_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]   SC_MAX    = SC_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

    fb_state_t         state, state_next;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
    logic [SC_W-1:0]   starve_cnt;
    logic              done_pend;

    logic starved_grant;
    logic disp_grant;
    logic clear_grant;
    logic wr_grant;
    logic clear_last;

    assign disp_data = mem_q;

    // Per-cycle arbitration and next-state. wr_ack high means the current
    // request was already served, so it is never granted twice.
    always_comb begin
        state_next    = state;
        clr_cnt_next  = clr_cnt;
        clear_grant   = 1'b0;
        wr_grant      = 1'b0;
        clear_last    = 1'b0;
        starved_grant = (state == ST_IDLE) && wr_req && !wr_ack &&
                        !clear_start && (starve_cnt == SC_MAX);
        disp_grant    = disp_req && !starved_grant;

        case (state)
            ST_CLEAR: begin
                clear_grant = !disp_grant;
                if (clear_grant) begin
                    if (clr_cnt == LAST_ADDR) begin
                        clear_last = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        clr_cnt_next = clr_cnt + ADDR_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (clear_start) begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = '0;
                end else begin
                    wr_grant = starved_grant ||
                               (wr_req && !wr_ack && !disp_grant);
                end
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    // State, clear counter and clear status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            busy       <= 1'b1;
            done_pend  <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_next;
            clr_cnt    <= clr_cnt_next;
            done_pend  <= clear_last;
            clear_done <= done_pend;
            busy       <= (state_next == ST_CLEAR) || clear_last;
        end
    end

    // Consecutive cycles a pending write has lost to the display.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!wr_req || wr_grant || wr_ack) begin
            starve_cnt <= '0;
        end else if ((state == ST_IDLE) && disp_grant && (starve_cnt != SC_MAX)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // Registered memory port and writer/display handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            wr_ack      <= 1'b0;
            wr_err      <= 1'b0;
            disp_miss   <= 1'b0;
        end else begin
            mem_wren  <= 1'b0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            disp_miss <= starved_grant && disp_req;
            if (wr_grant) begin
                mem_address <= wr_addr;
                mem_data    <= wr_data;
                mem_wren    <= (wr_addr < DEPTH_A);
                wr_ack      <= 1'b1;
                wr_err      <= (wr_addr >= DEPTH_A);
            end else if (disp_grant) begin
                mem_address <= disp_addr;
            end else if (clear_grant) begin
                mem_address <= clr_cnt;
                mem_data    <= CLEAR_COLOR;
                mem_wren    <= 1'b1;
            end
        end
    end

    fb_read_pipe u_read_pipe (
        .clk   (clk),
        .rst   (rst),
        .grant (disp_grant),
        .valid (disp_valid)
    );

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Directed self-checking bench for frame_buf_arbiter with a simple
// registered-read RAM standing in for vga_frame.
module tb_frame_buf_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [14:0] disp_addr;
    logic        disp_valid;
    logic [23:0] disp_data;
    logic        disp_miss;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [23:0] wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        clear_start;
    logic        busy;
    logic        clear_done;
    logic [14:0] mem_address;
    logic [23:0] mem_data;
    logic        mem_wren;
    logic [23:0] mem_q;

    logic [23:0] ram [0:31];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) ram[mem_address[4:0]] <= mem_data;
        mem_q <= ram[mem_address[4:0]];
    end

    frame_buf_arbiter #(
        .ADDR_W       (15),
        .DATA_W       (24),
        .DEPTH        (16),
        .CLEAR_COLOR  (24'h000000),
        .STARVE_LIMIT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_valid  (disp_valid),
        .disp_data   (disp_data),
        .disp_miss   (disp_miss),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({mem_wren, mem_address, mem_data, disp_valid, disp_miss, wr_ack, wr_err, clear_done, busy}
            !== {1'b0, 15'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
            begin n_fail++; $display("FAIL reset_state: wren=%b addr=%0d data=%h dv=%b miss=%b ack=%b err=%b done=%b busy=%b, want all 0 busy=1",
                mem_wren, mem_address, mem_data, disp_valid, disp_miss, wr_ack, wr_err, clear_done, busy); end
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_checks++;
            if ({mem_wren, mem_address, mem_data, clear_done, busy} !== {1'b1, 15'(k), 24'h000000, 1'b0, 1'b1})
                begin n_fail++; $display("FAIL clear_write[%0d]: wren=%b addr=%0d data=%h done=%b busy=%b, want 1 %0d 000000 0 1",
                    k, mem_wren, mem_address, mem_data, clear_done, busy, k); end
        end
        tick();
        n_checks++;
        if ({mem_wren, clear_done, busy} !== 3'b010)
            begin n_fail++; $display("FAIL clear_done: wren=%b done=%b busy=%b, want 0 1 0", mem_wren, clear_done, busy); end
        tick();
        n_checks++;
        if ({clear_done, busy} !== 2'b00)
            begin n_fail++; $display("FAIL clear_done_pulse: done=%b busy=%b, want 0 0", clear_done, busy); end
    endtask

    task automatic test_write;
        wr_req = 1'b1; wr_addr = 15'd3; wr_data = 24'hFF0000;
        tick();
        n_checks++;
        if ({mem_wren, mem_address, mem_data, wr_ack, wr_err} !== {1'b1, 15'd3, 24'hFF0000, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL write_grant: wren=%b addr=%0d data=%h ack=%b err=%b, want 1 3 ff0000 1 0",
                mem_wren, mem_address, mem_data, wr_ack, wr_err); end
        wr_req = 1'b0;
        tick();
        n_checks++;
        if ({mem_wren, wr_ack} !== 2'b00)
            begin n_fail++; $display("FAIL write_single: wren=%b ack=%b, want 0 0", mem_wren, wr_ack); end
        disp_req = 1'b1; disp_addr = 15'd3;
        tick();
        disp_req = 1'b0;
        tick();
        n_checks++;
        if ({disp_valid, disp_data} !== {1'b1, 24'hFF0000})
            begin n_fail++; $display("FAIL write_readback: valid=%b data=%h, want 1 ff0000", disp_valid, disp_data); end
    endtask

    task automatic test_read;
        wr_req = 1'b1; wr_addr = 15'd5; wr_data = 24'h00FF00;
        tick();
        wr_req = 1'b0;
        tick();
        disp_req = 1'b1; disp_addr = 15'd5;
        tick();
        n_checks++;
        if ({mem_wren, mem_address, disp_valid} !== {1'b0, 15'd5, 1'b0})
            begin n_fail++; $display("FAIL read_addr: wren=%b addr=%0d valid=%b, want 0 5 0", mem_wren, mem_address, disp_valid); end
        disp_req = 1'b0;
        tick();
        n_checks++;
        if ({disp_valid, disp_data} !== {1'b1, 24'h00FF00})
            begin n_fail++; $display("FAIL read_data: valid=%b data=%h, want 1 00ff00", disp_valid, disp_data); end
        tick();
        n_checks++;
        if (disp_valid !== 1'b0)
            begin n_fail++; $display("FAIL read_single: valid=%b, want 0", disp_valid); end
    endtask

    task automatic test_wr_err;
        wr_req = 1'b1; wr_addr = 15'd20; wr_data = 24'hABCDEF;
        tick();
        n_checks++;
        if ({wr_ack, wr_err, mem_wren} !== 3'b110)
            begin n_fail++; $display("FAIL wr_err: ack=%b err=%b wren=%b, want 1 1 0", wr_ack, wr_err, mem_wren); end
        wr_req = 1'b0;
        tick();
        n_checks++;
        if ({wr_ack, wr_err, mem_wren} !== 3'b000)
            begin n_fail++; $display("FAIL wr_err_pulse: ack=%b err=%b wren=%b, want 0 0 0", wr_ack, wr_err, mem_wren); end
    endtask

    task automatic test_starve;
        disp_req = 1'b1; disp_addr = 15'd5;
        wr_req = 1'b1; wr_addr = 15'd7; wr_data = 24'h123456;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if ({wr_ack, disp_miss, mem_wren, disp_valid} !== {1'b0, 1'b0, 1'b0, (k >= 2)})
                begin n_fail++; $display("FAIL starve_wait[%0d]: ack=%b miss=%b wren=%b valid=%b, want 0 0 0 %b",
                    k, wr_ack, disp_miss, mem_wren, disp_valid, (k >= 2)); end
        end
        tick();
        n_checks++;
        if ({wr_ack, disp_miss, mem_wren, mem_address, mem_data, disp_valid, disp_data}
            !== {1'b1, 1'b1, 1'b1, 15'd7, 24'h123456, 1'b1, 24'h00FF00})
            begin n_fail++; $display("FAIL starve_grant: ack=%b miss=%b wren=%b addr=%0d data=%h valid=%b rd=%h, want 1 1 1 7 123456 1 00ff00",
                wr_ack, disp_miss, mem_wren, mem_address, mem_data, disp_valid, disp_data); end
        wr_req = 1'b0;
        tick();
        n_checks++;
        if ({disp_valid, disp_miss, wr_ack, mem_wren} !== 4'b0000)
            begin n_fail++; $display("FAIL starve_dropped_read: valid=%b miss=%b ack=%b wren=%b, want 0 0 0 0",
                disp_valid, disp_miss, wr_ack, mem_wren); end
        tick();
        n_checks++;
        if ({disp_valid, disp_data, disp_miss} !== {1'b1, 24'h00FF00, 1'b0})
            begin n_fail++; $display("FAIL starve_resume: valid=%b data=%h miss=%b, want 1 00ff00 0",
                disp_valid, disp_data, disp_miss); end
        disp_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_clear_start;
        clear_start = 1'b1;
        wr_req = 1'b1; wr_addr = 15'd2; wr_data = 24'h777777;
        tick();
        n_checks++;
        if ({wr_ack, mem_wren, busy} !== 3'b001)
            begin n_fail++; $display("FAIL clear_start_idle: ack=%b wren=%b busy=%b, want 0 0 1", wr_ack, mem_wren, busy); end
        clear_start = 1'b0;
        wr_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) clear_start = 1'b1;
            if (k == 3) clear_start = 1'b0;
            tick();
            n_checks++;
            if ({mem_wren, mem_address, busy, wr_ack} !== {1'b1, 15'(k), 1'b1, 1'b0})
                begin n_fail++; $display("FAIL clear_run[%0d]: wren=%b addr=%0d busy=%b ack=%b, want 1 %0d 1 0",
                    k, mem_wren, mem_address, busy, wr_ack, k); end
        end
        disp_req = 1'b1; disp_addr = 15'd9;
        tick();
        n_checks++;
        if ({mem_wren, mem_address, busy} !== {1'b0, 15'd9, 1'b1})
            begin n_fail++; $display("FAIL clear_yield_display: wren=%b addr=%0d busy=%b, want 0 9 1", mem_wren, mem_address, busy); end
        disp_req = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({disp_valid, mem_wren, mem_address, busy} !== {1'b0, 1'b0, 15'd0, 1'b1})
            begin n_fail++; $display("FAIL reset_mid_clear: valid=%b wren=%b addr=%0d busy=%b, want 0 0 0 1",
                disp_valid, mem_wren, mem_address, busy); end
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_checks++;
            if ({mem_wren, mem_address, busy, disp_valid} !== {1'b1, 15'(k), 1'b1, 1'b0})
                begin n_fail++; $display("FAIL clear_restart[%0d]: wren=%b addr=%0d busy=%b valid=%b, want 1 %0d 1 0",
                    k, mem_wren, mem_address, busy, disp_valid, k); end
        end
        tick();
        n_checks++;
        if ({mem_wren, clear_done, busy} !== 3'b010)
            begin n_fail++; $display("FAIL clear_restart_done: wren=%b done=%b busy=%b, want 0 1 0", mem_wren, clear_done, busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        clear_start = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_wr_err();
        test_starve();
        test_clear_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
